// File: rtl/snn_pkg.sv
// Shared constants, FSM encoding and arithmetic helpers for the
// output neuron array: default LIF constants, state enum, saturating add.
package snn_pkg;

    localparam int TH_DEF   = 15018;
    localparam int D_DEF    = 614;
    localparam int PRES_DEF = 0;
    localparam int PMIN_DEF = -2048000;
    localparam int REF_DEF  = 30;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_EVAL,
        S_LEARN,
        S_DONE
    } state_e;

    // Wide add, then clamp to [lo, hi] so narrow potentials never wrap.
    function automatic longint sat_add(
        input longint a,
        input longint b,
        input longint lo,
        input longint hi
    );
        longint s;
        s = a + b;
        if (s < lo)
            sat_add = lo;
        else if (s > hi)
            sat_add = hi;
        else
            sat_add = s;
    endfunction

endpackage

// File: rtl/out_nu_array_if.sv
// Weight RAM read bus and learning handshake of the output neuron array.
// master: neuron array (drives w_addr/w_rd/learn_req/learn_idx); slave: RAM + learner.
interface out_nu_array_if #(
    parameter int N_OUT = 8,
    parameter int W     = 24,
    parameter int AW    = 10
);
    localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic [AW-1:0]      w_addr;
    logic               w_rd;
    logic [N_OUT*W-1:0] w_data;
    logic               learn_req;
    logic [IW-1:0]      learn_idx;
    logic               learn_ack;

    modport master (
        output w_addr, w_rd, learn_req, learn_idx,
        input  w_data, learn_ack
    );

    modport slave (
        input  w_addr, w_rd, learn_req, learn_idx,
        output w_data, learn_ack
    );

endinterface

// File: rtl/out_nu_array_wta_select.sv
// Combinational argmax over N signed potentials restricted to a candidate mask.
// Ports: pot_i (packed potentials), mask_i, idx_o (winner), valid_o (any candidate).
module wta_select #(
    parameter int N  = 8,
    parameter int W  = 24,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N*W-1:0] pot_i,
    input  logic [N-1:0]   mask_i,
    output logic [IW-1:0]  idx_o,
    output logic           valid_o
);
    logic signed [W-1:0] best;
    logic                found;

    // Strict '>' keeps the earlier (lower) index on ties.
    always_comb begin
        best  = '0;
        found = 1'b0;
        idx_o = '0;
        for (int j = 0; j < N; j++) begin
            if (mask_i[j] && (!found || $signed(pot_i[j*W +: W]) > best)) begin
                best  = $signed(pot_i[j*W +: W]);
                idx_o = IW'(j);
                found = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/out_nu_array.sv
// Array of N_OUT leaky integrate-and-fire neurons stepped once per timestep.
// Ports: clk/rst, start_core_img, step_start, spike_in, li_en, learn_en,
// bus (weight RAM + learn handshake), spike_out, potential, step_valid, busy.
module out_nu_array
    import snn_pkg::*;
#(
    parameter int     N_IN  = 784,
    parameter int     N_OUT = 8,
    parameter int     W     = 24,
    parameter int     AW    = 10,
    parameter int     TH    = TH_DEF,
    parameter int     D     = D_DEF,
    parameter int     PRES  = PRES_DEF,
    parameter int     PMIN  = PMIN_DEF,
    parameter longint PMAX  = (longint'(1) << (W - 1)) - 1,
    parameter int     REF   = REF_DEF,
    parameter int     RW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_core_img,
    input  logic               step_start,
    input  logic [N_IN-1:0]    spike_in,
    input  logic               li_en,
    input  logic               learn_en,
    out_nu_array_if.master     bus,
    output logic [N_OUT-1:0]   spike_out,
    output logic [N_OUT*W-1:0] potential,
    output logic               step_valid,
    output logic               busy
);
    localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int CW = $clog2(N_IN + 1);

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [N_IN-1:0]     spk_sh_q;
    logic                li_q;
    logic                le_q;
    logic signed [W-1:0] pot_q [N_OUT];
    logic [RW-1:0]       ref_q [N_OUT];
    logic [N_OUT-1:0]    fire_q;
    logic                w_rd_q;
    logic [AW-1:0]       w_addr_q;
    logic                req_q;
    logic [IW-1:0]       idx_q;

    logic [N_OUT*W-1:0]  leak_flat;
    logic [N_OUT-1:0]    cand_c;
    logic [N_OUT-1:0]    fire_c;
    logic [IW-1:0]       win_idx;
    logic                win_vld;
    logic [IW-1:0]       low_idx;
    longint              p;
    longint              lk;

    // Leak toward PRES without crossing it; candidates use leaked value.
    always_comb begin
        leak_flat = '0;
        cand_c    = '0;
        p         = 0;
        lk        = 0;
        for (int j = 0; j < N_OUT; j++) begin
            p = longint'(pot_q[j]);
            if (p > longint'(PRES))
                lk = (p - D < longint'(PRES)) ? longint'(PRES) : p - D;
            else
                lk = (p + D > longint'(PRES)) ? longint'(PRES) : p + D;
            leak_flat[j*W +: W] = W'(lk);
            cand_c[j] = (ref_q[j] == '0) && (lk >= longint'(TH));
        end
    end

    wta_select #(
        .N (N_OUT),
        .W (W),
        .IW(IW)
    ) u_wta (
        .pot_i  (leak_flat),
        .mask_i (cand_c),
        .idx_o  (win_idx),
        .valid_o(win_vld)
    );

    always_comb begin
        if (li_q)
            fire_c = win_vld ? (N_OUT'(1) << win_idx) : '0;
        else
            fire_c = cand_c;
        low_idx = '0;
        for (int j = N_OUT - 1; j >= 0; j--)
            if (fire_c[j])
                low_idx = IW'(j);
    end

    always_ff @(posedge clk) begin
        if (rst || start_core_img) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            w_rd_q   <= 1'b0;
            w_addr_q <= '0;
            req_q    <= 1'b0;
            fire_q   <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                pot_q[j] <= W'(PRES);
                ref_q[j] <= '0;
            end
            if (rst) begin
                spk_sh_q <= '0;
                li_q     <= 1'b0;
                le_q     <= 1'b0;
                idx_q    <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (step_start) begin
                        spk_sh_q <= spike_in;
                        li_q     <= li_en;
                        le_q     <= learn_en;
                        cnt_q    <= '0;
                        w_rd_q   <= 1'b1;
                        w_addr_q <= '0;
                        state_q  <= S_ACC;
                    end
                end
                S_ACC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (int'(cnt_q) + 1 < N_IN) begin
                        w_addr_q <= w_addr_q + 1'b1;
                    end else begin
                        w_rd_q   <= 1'b0;
                        w_addr_q <= '0;
                    end
                    // Row k arrives one cycle after its read; the
                    // shift register lines spike k up with it.
                    if (cnt_q != '0) begin
                        spk_sh_q <= spk_sh_q >> 1;
                        if (spk_sh_q[0]) begin
                            for (int j = 0; j < N_OUT; j++)
                                if (ref_q[j] == '0)
                                    pot_q[j] <= W'(sat_add(
                                        longint'(pot_q[j]),
                                        longint'($signed(bus.w_data[j*W +: W])),
                                        longint'(PMIN), PMAX));
                        end
                    end
                    if (cnt_q == CW'(N_IN))
                        state_q <= S_EVAL;
                end
                S_EVAL: begin
                    for (int j = 0; j < N_OUT; j++) begin
                        if (ref_q[j] != '0) begin
                            ref_q[j] <= ref_q[j] - 1'b1;
                            pot_q[j] <= W'(PRES);
                        end else if (fire_c[j]) begin
                            pot_q[j] <= W'(PRES);
                            ref_q[j] <= RW'(REF);
                        end else if (li_q && win_vld) begin
                            pot_q[j] <= W'(PRES);
                        end else begin
                            pot_q[j] <= $signed(leak_flat[j*W +: W]);
                        end
                    end
                    fire_q <= fire_c;
                    if (le_q && |fire_c) begin
                        req_q   <= 1'b1;
                        idx_q   <= low_idx;
                        state_q <= S_LEARN;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                S_LEARN: begin
                    if (bus.learn_ack) begin
                        req_q   <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        potential = '0;
        for (int j = 0; j < N_OUT; j++)
            potential[j*W +: W] = pot_q[j];
    end

    assign step_valid    = (state_q == S_DONE);
    assign spike_out     = step_valid ? fire_q : '0;
    assign busy          = (state_q != S_IDLE);
    assign bus.w_rd      = w_rd_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.learn_req = req_q;
    assign bus.learn_idx = idx_q;

endmodule

// File: tb/tb_out_nu_array.sv
// Randomised and directed bench for out_nu_array against a behavioural
// model of the neuron rules (accumulate, leak, threshold, WTA, refractory).
module tb_out_nu_array;
    localparam int NI  = 4;
    localparam int NO  = 4;
    localparam int WW  = 16;
    localparam int AWW = 2;
    localparam int THR = 100;
    localparam int DL  = 10;
    localparam int RF  = 2;
    localparam int PMN = -20000;
    localparam int PMX = 32767;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           start_core_img;
    logic           step_start;
    logic [NI-1:0]  spike_in;
    logic           li_en;
    logic           learn_en;
    logic [NO-1:0]  spike_out;
    logic [NO*WW-1:0] potential;
    logic           step_valid;
    logic           busy;

    out_nu_array_if #(.N_OUT(NO), .W(WW), .AW(AWW)) bus ();

    out_nu_array #(
        .N_IN(NI), .N_OUT(NO), .W(WW), .AW(AWW), .TH(THR), .D(DL),
        .PRES(0), .PMIN(PMN), .PMAX(PMX), .REF(RF), .RW(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_core_img(start_core_img),
        .step_start    (step_start),
        .spike_in      (spike_in),
        .li_en         (li_en),
        .learn_en      (learn_en),
        .bus           (bus),
        .spike_out     (spike_out),
        .potential     (potential),
        .step_valid    (step_valid),
        .busy          (busy)
    );

    int wmem [NI][NO];

    always @(posedge clk)
        if (bus.w_rd)
            for (int j = 0; j < NO; j++)
                bus.w_data[j*WW +: WW] <= WW'(wmem[int'(bus.w_addr)][j]);

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Behavioural model state
    int            mpot [NO];
    int            mref [NO];
    int            macc [NO];
    logic [NO-1:0] mfire;
    bit            mlearn;
    int            midx;

    function automatic int clampv(input int v);
        if (v < PMN) return PMN;
        if (v > PMX) return PMX;
        return v;
    endfunction

    task automatic model_clear();
        for (int j = 0; j < NO; j++) begin
            mpot[j] = 0;
            mref[j] = 0;
        end
    endtask

    task automatic model_step(input logic [NI-1:0] s, input bit li, input bit le);
        int lk [NO];
        bit cand [NO];
        int win;
        for (int k = 0; k < NI; k++)
            if (s[k])
                for (int j = 0; j < NO; j++)
                    if (mref[j] == 0)
                        mpot[j] = clampv(mpot[j] + wmem[k][j]);
        for (int j = 0; j < NO; j++) begin
            macc[j] = mpot[j];
            if (mpot[j] > 0)
                lk[j] = (mpot[j] - DL < 0) ? 0 : mpot[j] - DL;
            else
                lk[j] = (mpot[j] + DL > 0) ? 0 : mpot[j] + DL;
            cand[j] = (mref[j] == 0) && (lk[j] >= THR);
        end
        mfire = '0;
        win = -1;
        for (int j = 0; j < NO; j++)
            if (cand[j]) begin
                if (!li)
                    mfire[j] = 1'b1;
                else if (win < 0 || lk[j] > lk[win])
                    win = j;
            end
        if (li && win >= 0)
            mfire[win] = 1'b1;
        for (int j = 0; j < NO; j++) begin
            if (mref[j] > 0) begin
                mref[j]--;
                mpot[j] = 0;
            end else if (mfire[j]) begin
                mpot[j] = 0;
                mref[j] = RF;
            end else if (li && win >= 0) begin
                mpot[j] = 0;
            end else begin
                mpot[j] = lk[j];
            end
        end
        mlearn = le && (mfire != '0);
        midx = 0;
        for (int j = NO - 1; j >= 0; j--)
            if (mfire[j])
                midx = j;
    endtask

    function automatic int pot_of(input int j);
        logic signed [WW-1:0] v;
        v = potential[j*WW +: WW];
        return int'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        start_core_img = 1'b1;
        tick();
        start_core_img = 1'b0;
        model_clear();
    endtask

    task automatic check_pots(input string tag);
        for (int j = 0; j < NO; j++)
            check(tag, pot_of(j), mpot[j]);
    endtask

    task automatic do_step(input logic [NI-1:0] s, input bit li,
                           input bit le, input int ack_dly);
        int cyc;
        model_step(s, li, le);
        spike_in   = s;
        li_en      = li;
        learn_en   = le;
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        cyc = 1;
        check("busy_start", int'(busy), 1);
        while (!step_valid && !bus.learn_req && cyc < 50) begin
            // Disturb inputs mid-step: must all be ignored while busy.
            if (cyc == 3) begin
                step_start    = 1'b1;
                spike_in      = ~s;
                li_en         = ~li;
                learn_en      = ~le;
                bus.learn_ack = 1'b1;
            end else begin
                step_start    = 1'b0;
                bus.learn_ack = 1'b0;
            end
            if (cyc == 6)
                for (int j = 0; j < NO; j++)
                    check("acc_pot", pot_of(j), macc[j]);
            tick();
            cyc++;
        end
        step_start    = 1'b0;
        bus.learn_ack = 1'b0;
        check("eval_lat", cyc, 7);
        check("learn_req", int'(bus.learn_req), int'(mlearn));
        if (bus.learn_req) begin
            check("learn_idx", int'(bus.learn_idx), midx);
            for (int i = 0; i < ack_dly; i++) begin
                tick();
                check("req_hold", int'({bus.learn_req, step_valid}), 2);
                check("idx_hold", int'(bus.learn_idx), midx);
            end
            bus.learn_ack = 1'b1;
            tick();
            bus.learn_ack = 1'b0;
            check("ack_done", int'({bus.learn_req, step_valid}), 1);
        end
        check("step_valid", int'(step_valid), 1);
        check("spike_out", int'(spike_out), int'(mfire));
        check_pots("pot");
        tick();
        check("post_step", int'({step_valid, busy, spike_out}), 0);
    endtask

    task automatic no_valid_for(input int n, input string tag);
        int v;
        v = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            v += int'(step_valid);
        end
        check(tag, v, 0);
    endtask

    task automatic zero_w();
        for (int k = 0; k < NI; k++)
            for (int j = 0; j < NO; j++)
                wmem[k][j] = 0;
    endtask

    initial begin
        int cyc;
        rst            = 1'b1;
        start_core_img = 1'b0;
        step_start     = 1'b0;
        spike_in       = '0;
        li_en          = 1'b0;
        learn_en       = 1'b0;
        bus.learn_ack  = 1'b0;
        zero_w();
        model_clear();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_outs", int'({spike_out, step_valid, busy, bus.learn_req,
                                bus.w_rd, bus.w_addr, bus.learn_idx}), 0);
        check("rst_pot", int'(potential), 0);

        // Empty step: latency and quiet outputs
        do_step(4'b0000, 1'b0, 1'b0, 0);

        // Accumulate + leak, then refractory for two steps
        wmem[0][0] = 50;
        wmem[1][0] = 60;
        repeat (4) do_step(4'b0011, 1'b0, 1'b0, 0);

        // Winner-take-all versus independent firing
        clear_img();
        zero_w();
        wmem[2][1] = 130;
        wmem[2][2] = 160;
        do_step(4'b0100, 1'b1, 1'b0, 0);
        clear_img();
        do_step(4'b0100, 1'b0, 1'b0, 0);

        // Learning handshake with delayed ack
        clear_img();
        zero_w();
        wmem[3][3] = 200;
        do_step(4'b1000, 1'b0, 1'b1, 5);

        // Floor then ceiling saturation
        clear_img();
        for (int k = 0; k < NI; k++)
            for (int j = 0; j < NO; j++)
                wmem[k][j] = -32768;
        do_step(4'b1111, 1'b0, 1'b0, 0);
        for (int k = 0; k < NI; k++)
            for (int j = 0; j < NO; j++)
                wmem[k][j] = 32767;
        do_step(4'b1111, 1'b0, 1'b0, 0);

        // Abort mid-ACC
        clear_img();
        zero_w();
        wmem[0][1] = 300;
        spike_in   = 4'b0001;
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        repeat (2) tick();
        clear_img();
        check("abort_acc_busy", int'(busy), 0);
        check_pots("abort_acc_pot");
        no_valid_for(10, "abort_acc_valid");

        // Abort mid-LEARN
        learn_en   = 1'b1;
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        cyc = 1;
        while (!bus.learn_req && cyc < 50) begin
            tick();
            cyc++;
        end
        check("abort_req_seen", int'(bus.learn_req), 1);
        repeat (2) tick();
        clear_img();
        check("abort_learn", int'({bus.learn_req, busy, step_valid}), 0);
        check_pots("abort_learn_pot");
        no_valid_for(10, "abort_learn_valid");
        learn_en = 1'b0;

        // Randomised steps against the model
        for (int n = 0; n < 40; n++) begin
            if (n % 5 == 0)
                for (int k = 0; k < NI; k++)
                    for (int j = 0; j < NO; j++)
                        wmem[k][j] = int'($urandom_range(0, 500)) - 150;
            if ($urandom_range(0, 7) == 0)
                clear_img();
            do_step(NI'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/out_nu_array.md
Name: out_nu_array

Overview:
- Parametrised successor of the single output neuron. Holds N_OUT leaky integrate-and-fire neurons and evaluates them together once per timestep.
- Fetches one weight row per input from an external weight RAM and accumulates the rows of active input spikes.
- Applies leak, threshold and refractory, plus optional winner-take-all lateral inhibition.
- Hands the winner to the weight-change unit through a req/ack handshake. Sits between the input spike buffer and the layer's learning block.

Parameters:
N_IN, 784, number of input (pre-synaptic) lines
N_OUT, 8, number of output neurons
W, 24, signed weight and potential width
AW, 10, weight RAM address width (2^AW >= N_IN)
TH, 15018, firing threshold (3.666*4096)
D, 614, leak per timestep toward PRES (0.15*4096)
PRES, 0, resting potential
PMIN, -2048000, potential floor (-500*4096)
PMAX, 2^(W-1)-1, potential ceiling
REF, 30, refractory length in timesteps
RW, 8, refractory counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_core_img  in  1  new image: clear all potentials and refractory state, abort any step
step_start  in  1  one-cycle pulse: run one timestep
spike_in  in  N_IN  input spike vector, sampled on step_start
li_en  in  1  lateral inhibition enable, sampled on step_start
learn_en  in  1  learning enable, sampled on step_start
w_addr  out  AW  weight RAM read address (row = input index)
w_rd  out  1  read strobe
w_data  in  N_OUT*W  weight row; neuron j in bits [j*W +: W]; valid 1 cycle after w_rd
learn_req  out  1  request weight update for learn_idx
learn_idx  out  clog2(N_OUT)  winner index
learn_ack  in  1  weight update complete
spike_out  out  N_OUT  output spikes, valid with step_valid
potential  out  N_OUT*W  current potentials
step_valid  out  1  one-cycle pulse: timestep complete
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - Outputs: state=IDLE; all outputs 0; potentials=PRES; refractory counters=0.
  - rst overrides every other input.
- start_core_img (second priority, any state):
  - Next state IDLE; potentials=PRES; refractory counters=0; learn_req dropped; no step_valid.
- States: IDLE, ACC, EVAL, LEARN, DONE.
- IDLE:
  - step_start latches spike_in, li_en and learn_en, then goes to ACC.
  - step_start is ignored in every other state.
- ACC:
  - Cycles k=0..N_IN-1: w_rd=1, w_addr=k.
  - Cycle k+1: if latched spike_in[k]=1, add w_data slice j to potential j for every non-refractory neuron.
  - Each add saturates to [PMIN,PMAX] immediately.
  - ACC lasts N_IN+1 cycles, then goes to EVAL.
- EVAL, one cycle:
  - Non-refractory neurons leak toward PRES by D; the leak never crosses PRES.
  - A non-refractory neuron is a candidate if its leaked potential >= TH.
  - li_en=0: every candidate spikes.
  - li_en=1: only the candidate with the highest potential spikes (ties go to the lowest index). All other non-refractory potentials reset to PRES.
  - Each spiking neuron: potential reset to PRES, refractory counter = REF.
  - Neurons already refractory: counter decrements by 1; potential held at PRES.
  - Next state: LEARN if learn_en=1 and at least one neuron spiked, else DONE.
- LEARN:
  - learn_req=1, and learn_idx = lowest-index spiking neuron, held stable until learn_ack is sampled high.
  - learn_req drops on the cycle after the ack; next state DONE.
  - learn_ack outside LEARN is ignored.
- DONE:
  - step_valid=1 and spike_out set for exactly this cycle; spike_out is 0 otherwise.
  - Next state IDLE.
- Latency with no learning: step_valid asserts N_IN+3 cycles after the step_start edge.
- potential reflects registered values at all times.

Decomposition:
- snn_pkg: default constants (TH, D, PRES, PMIN, REF), the state encoding, and a saturating signed add function.
- One sub-module: wta_select.
  - Combinational argmax over N_OUT signed potentials with a candidate mask.
  - Outputs winner index and valid; lowest index wins ties.

Test Plan:
All tests use N_IN=4, N_OUT=4, TH=100, D=10, REF=2, PRES=0, W=16 unless stated.
1. Reset/latency: release rst; check all outputs 0. Pulse step_start with spike_in=0 -> step_valid exactly 7 cycles later, spike_out=0, potentials 0.
2. Accumulate+leak: weights row0={50,0,0,0}, row1={60,0,0,0}; spike_in=0011 -> neuron0 reaches 110-10=100 >= TH and spikes. Its potential becomes 0 and it is refractory for the next 2 steps; inputs are ignored there.
3. WTA: li_en=1; neurons 1 and 2 end at 120 and 150 -> only neuron2 spikes; neuron1 potential becomes 0. Repeat with li_en=0 -> both spike.
4. Learn handshake: learn_en=1 with neuron3 spiking; delay learn_ack 5 cycles. learn_req holds with learn_idx=3, and step_valid follows the cycle after the ack.
5. Saturation/floor: weights -32768 on all four inputs -> potential clamps at PMIN and no wrap. Then positive weights clamp at PMAX.
6. Abort: assert start_core_img mid-ACC and again mid-LEARN -> IDLE next cycle, potentials 0, no step_valid. A step_start during busy has no effect.
